alu_arbiter: RTL and testbench

- Shares one combinational 8-bit ALU (ports oper, a, b, c_in -> sum, c_out) between two requesters.
- Each requester issues operations over a valid/ready request channel. It collects the result over a valid/ready response channel.
- Round-robin arbitration, a 3-state sequencer, registered ALU operands and a registered result.
- Sits between the ALU and the two client blocks (e.g. address-gen and data-path sequencers).

---
 rtl/alu_arb_pkg.sv | 15 +
 rtl/alu_arbiter_if.sv | 31 +++
 rtl/alu_arbiter_rr_arb2.sv | 16 +
 rtl/alu_arbiter.sv | 114 +++++++++++
 tb/tb_alu_arbiter.sv | 276 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: sequencer encoding and
// default datapath widths.
package alu_arb_pkg;

   localparam int WIDTH_DEF  = 8;
   localparam int OPER_W_DEF = 3;
   localparam int CNT_W_DEF  = 16;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

endpackage

// File: rtl/alu_arbiter_if.sv
// Client-side request/response channels of the ALU arbiter. Both requesters share
// one bundle: request fields are packed per requester, and the result bus is common.
interface alu_arbiter_if
   import alu_arb_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int OPER_W = OPER_W_DEF
);

   logic [1:0]          req_valid;
   logic [1:0]          req_ready;
   logic [2*OPER_W-1:0] req_oper;
   logic [2*WIDTH-1:0]  req_a;
   logic [2*WIDTH-1:0]  req_b;
   logic [1:0]          req_c_in;
   logic [1:0]          rsp_valid;
   logic [1:0]          rsp_ready;
   logic [WIDTH-1:0]    rsp_sum;
   logic                rsp_c_out;

   modport master (
      output req_valid, req_oper, req_a, req_b, req_c_in, rsp_ready,
      input  req_ready, rsp_valid, rsp_sum, rsp_c_out
   );

   modport slave (
      input  req_valid, req_oper, req_a, req_b, req_c_in, rsp_ready,
      output req_ready, rsp_valid, rsp_sum, rsp_c_out
   );

endinterface

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way round-robin pick. The grant is one-hot or zero. When both requesters
// are valid, prio selects the winner.
module rr_arb2 (
   input  logic [1:0] req,
   input  logic       prio,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = req;
      if (req == 2'b11) begin
         gnt = prio ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: rtl/alu_arbiter.sv
// Time-shares one combinational ALU between two valid/ready requesters. The ALU
// operands and the result are registered, and requesters are served in round-robin.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | arbitrate; the winner's operands are latched into alu_* on accept
//   EXEC  | ALU settles on registered operands; result captured at edge
//   RESP  | rsp_valid[grant] held until rsp_ready[grant]
module alu_arbiter
   import alu_arb_pkg::*;
#(
   parameter int WIDTH  = WIDTH_DEF,
   parameter int OPER_W = OPER_W_DEF,
   parameter int CNT_W  = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   alu_arbiter_if.slave      bus,
   output logic [OPER_W-1:0] alu_oper,
   output logic [WIDTH-1:0]  alu_a,
   output logic [WIDTH-1:0]  alu_b,
   output logic              alu_c_in,
   input  logic [WIDTH-1:0]  alu_sum,
   input  logic              alu_c_out,
   output logic              busy,
   output logic [CNT_W-1:0]  done_cnt
);

   state_t     state;
   state_t     state_nxt;
   logic       prio;
   logic       grant;
   logic [1:0] gnt;
   logic       accept;
   logic       rsp_hs;
   logic       sel;

   rr_arb2 u_arb (
      .req  (bus.req_valid),
      .prio (prio),
      .gnt  (gnt)
   );

   assign sel = gnt[1];

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      bus.req_ready = 2'b00;
      bus.rsp_valid = 2'b00;
      busy          = (state != IDLE);
      accept        = 1'b0;
      rsp_hs        = 1'b0;
      case (state)
         IDLE: begin
            if (!rst) begin
               bus.req_ready = gnt;
               if (gnt != 2'b00) begin
                  accept    = 1'b1;
                  state_nxt = EXEC;
               end
            end
         end
         EXEC: state_nxt = RESP;
         RESP: begin
            bus.rsp_valid = grant ? 2'b10 : 2'b01;
            if (bus.rsp_ready[grant]) begin
               rsp_hs    = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // alu_* hold their last operands between operations; only a new accept moves them
   always_ff @(posedge clk) begin
      if (rst) begin
         prio          <= 1'b0;
         grant         <= 1'b0;
         alu_oper      <= '0;
         alu_a         <= '0;
         alu_b         <= '0;
         alu_c_in      <= 1'b0;
         bus.rsp_sum   <= '0;
         bus.rsp_c_out <= 1'b0;
         done_cnt      <= '0;
      end else begin
         if (accept) begin
            grant    <= sel;
            prio     <= ~sel;
            alu_oper <= sel ? bus.req_oper[2*OPER_W-1:OPER_W] : bus.req_oper[OPER_W-1:0];
            alu_a    <= sel ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
            alu_b    <= sel ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
            alu_c_in <= bus.req_c_in[sel];
         end
         if (state == EXEC) begin
            bus.rsp_sum   <= alu_sum;
            bus.rsp_c_out <= alu_c_out;
         end
         if (rsp_hs) begin
            done_cnt <= done_cnt + CNT_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter. Expected responses are queued at accept time
// and matched against the DUT outputs by an independent monitor.
module tb_alu_arbiter;

   typedef struct {
      int         idx;
      logic [2:0] oper;
      logic [7:0] a;
      logic [7:0] b;
      logic       cin;
      logic [7:0] es;
      logic       ec;
      int         acc_cyc;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst;
   logic       rv0, rv1, c0, c1;
   logic [2:0] op0, op1;
   logic [7:0] a0, a1, b0, b1;
   logic [1:0] rr;

   logic [2:0] alu_oper;
   logic [7:0] alu_a, alu_b, alu_sum;
   logic       alu_c_in, alu_c_out, busy;
   logic [3:0] done_cnt;
   logic [8:0] alu_res;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   int   exp_done = 0;
   bit   mprio = 1'b0;
   logic [1:0] prev_rv = 2'b00;

   vec_t tbl[8];
   vec_t pend0[$];
   vec_t pend1[$];
   vec_t sb[$];

   alu_arbiter_if #(.WIDTH(8), .OPER_W(3)) ifc ();

   assign ifc.req_valid = {rv1, rv0};
   assign ifc.req_oper  = {op1, op0};
   assign ifc.req_a     = {a1, a0};
   assign ifc.req_b     = {b1, b0};
   assign ifc.req_c_in  = {c1, c0};
   assign ifc.rsp_ready = rr;

   assign alu_res   = {1'b0, alu_a} + {1'b0, alu_b} + {8'b0, alu_c_in};
   assign alu_sum   = alu_res[7:0];
   assign alu_c_out = alu_res[8];

   alu_arbiter #(.WIDTH(8), .OPER_W(3), .CNT_W(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (ifc),
      .alu_oper  (alu_oper),
      .alu_a     (alu_a),
      .alu_b     (alu_b),
      .alu_c_in  (alu_c_in),
      .alu_sum   (alu_sum),
      .alu_c_out (alu_c_out),
      .busy      (busy),
      .done_cnt  (done_cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic vec_t mk(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                               input logic c, input logic [7:0] s, input logic co);
      vec_t v;
      v.idx = 0; v.oper = o; v.a = a; v.b = b; v.cin = c; v.es = s; v.ec = co; v.acc_cyc = 0;
      return v;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail_now(input string name);
      total++;
      bad++;
      $display("FAIL %s: got timeout expected event", name);
   endtask

   task automatic drive_pend();
      rv0 = (pend0.size() > 0);
      rv1 = (pend1.size() > 0);
      if (rv0) begin op0 = pend0[0].oper; a0 = pend0[0].a; b0 = pend0[0].b; c0 = pend0[0].cin; end
      if (rv1) begin op1 = pend1[0].oper; a1 = pend1[0].a; b1 = pend1[0].b; c1 = pend1[0].cin; end
   endtask

   // enter and leave at posedge+1; the model arbiter decides the expected winner
   task automatic issue();
      int guard = 0;
      while ((pend0.size() > 0 || pend1.size() > 0) && guard < 100) begin
         drive_pend();
         @(negedge clk);
         if (ifc.req_ready != 2'b00) begin
            logic [1:0] w;
            vec_t v;
            w = (rv0 && rv1) ? (mprio ? 2'b10 : 2'b01) : {rv1, rv0};
            chk("req_ready_winner", 32'(ifc.req_ready), 32'(w));
            if (w == 2'b01) begin
               v = pend0.pop_front(); v.idx = 0; v.acc_cyc = cyc; sb.push_back(v); mprio = 1'b1;
            end else if (w == 2'b10) begin
               v = pend1.pop_front(); v.idx = 1; v.acc_cyc = cyc; sb.push_back(v); mprio = 1'b0;
            end
         end
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) fail_now("issue_timeout");
      rv0 = 1'b0;
      rv1 = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (sb.size() > 0 && g < 100) begin
         @(negedge clk);
         g++;
      end
      if (g >= 100) fail_now("drain_timeout");
      @(posedge clk); #1;
   endtask

   // monitor: pops the scoreboard on every response handshake
   initial begin
      forever begin
         @(negedge clk);
         if (rst) begin
            sb.delete();
            exp_done = 0;
            prev_rv  = 2'b00;
            mprio    = 1'b0;
         end else begin
            chk("done_cnt", 32'(done_cnt), exp_done);
            if (ifc.rsp_valid == 2'b11) fail_now("rsp_valid_both");
            if (ifc.rsp_valid != 2'b00) begin
               if (sb.size() == 0) begin
                  total++; bad++;
                  $display("FAIL unexpected_rsp: got rsp_valid=%b expected none", ifc.rsp_valid);
               end else begin
                  if (prev_rv == 2'b00) begin
                     chk("latency", cyc, sb[0].acc_cyc + 2);
                     chk("alu_oper", 32'(alu_oper), 32'(sb[0].oper));
                     chk("alu_a", 32'(alu_a), 32'(sb[0].a));
                     chk("alu_b", 32'(alu_b), 32'(sb[0].b));
                     chk("alu_c_in", 32'(alu_c_in), 32'(sb[0].cin));
                  end
                  chk("rsp_valid_idx", 32'(ifc.rsp_valid), (sb[0].idx == 1) ? 32'd2 : 32'd1);
                  chk("rsp_sum", 32'(ifc.rsp_sum), 32'(sb[0].es));
                  chk("rsp_c_out", 32'(ifc.rsp_c_out), 32'(sb[0].ec));
                  if ((ifc.rsp_valid & rr) != 2'b00) begin
                     void'(sb.pop_front());
                     exp_done = (exp_done + 1) % 16;
                  end
               end
            end
            prev_rv = ifc.rsp_valid;
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int g;
      rst = 1'b1; rr = 2'b11;
      rv0 = 0; rv1 = 0; op0 = 0; op1 = 0; a0 = 0; a1 = 0; b0 = 0; b1 = 0; c0 = 0; c1 = 0;
      tbl[0] = mk(3'd0, 8'h9D, 8'hD7, 1'b0, 8'h74, 1'b1);
      tbl[1] = mk(3'd1, 8'h01, 8'h01, 1'b1, 8'h03, 1'b0);
      tbl[2] = mk(3'd2, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1);
      tbl[3] = mk(3'd3, 8'h80, 8'h7F, 1'b0, 8'hFF, 1'b0);
      tbl[4] = mk(3'd5, 8'h55, 8'hAA, 1'b1, 8'h00, 1'b1);
      tbl[5] = mk(3'd7, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0);
      tbl[6] = mk(3'd4, 8'hC8, 8'h64, 1'b1, 8'h2D, 1'b1);
      tbl[7] = mk(3'd6, 8'h3C, 8'hC3, 1'b0, 8'hFF, 1'b0);

      // both requesters already valid while reset is held
      pend0.push_back(tbl[0]);
      pend1.push_back(tbl[1]);
      drive_pend();
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_req_ready", 32'(ifc.req_ready), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("rst_done_cnt", 32'(done_cnt), 32'd0);
      chk("rst_alu_a", 32'(alu_a), 32'd0);
      chk("rst_alu_oper", 32'(alu_oper), 32'd0);
      chk("rst_rsp_sum", 32'(ifc.rsp_sum), 32'd0);
      chk("rst_rsp_c_out", 32'(ifc.rsp_c_out), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0;

      issue(); drain();

      pend0.push_back(tbl[0]);
      issue(); drain();

      pend0.push_back(tbl[2]); pend0.push_back(tbl[4]); pend0.push_back(tbl[6]); pend0.push_back(tbl[0]);
      pend1.push_back(tbl[3]); pend1.push_back(tbl[5]); pend1.push_back(tbl[7]); pend1.push_back(tbl[1]);
      issue(); drain();
      chk("done_after_fair", 32'(done_cnt), 32'd11);

      // response held off while the other requester waits
      rr = 2'b10;
      pend0.push_back(tbl[5]);
      issue();
      rv1 = 1'b1; op1 = 3'd1; a1 = 8'h11; b1 = 8'h22; c1 = 1'b0;
      g = 0;
      do begin
         @(negedge clk);
         g++;
      end while (!ifc.rsp_valid[0] && g < 10);
      if (g >= 10) fail_now("bp_wait");
      repeat (5) begin
         @(negedge clk);
         chk("bp_rsp_valid", 32'(ifc.rsp_valid), 32'd1);
         chk("bp_rsp_sum", 32'(ifc.rsp_sum), 32'(tbl[5].es));
         chk("bp_req_ready", 32'(ifc.req_ready), 32'd0);
         chk("bp_busy", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      rv1 = 1'b0;
      rr = 2'b11;
      @(negedge clk);
      @(negedge clk);
      chk("bp_idle", 32'(busy), 32'd0);
      chk("alu_a_hold", 32'(alu_a), 32'(tbl[5].a));
      @(posedge clk); #1;

      // reset while the accepted op is in EXEC
      pend0.push_back(tbl[3]);
      issue();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_rsp_valid", 32'(ifc.rsp_valid), 32'd0);
      chk("midrst_done_cnt", 32'(done_cnt), 32'd0);
      repeat (4) begin
         @(negedge clk);
         chk("no_dropped_rsp", 32'(ifc.rsp_valid), 32'd0);
      end
      @(posedge clk); #1;

      pend0.push_back(tbl[6]);
      pend1.push_back(tbl[7]);
      issue(); drain();

      for (int k = 0; k < 13; k++) pend1.push_back(tbl[k % 8]);
      issue(); drain();
      chk("pre_wrap", 32'(done_cnt), 32'd15);
      pend0.push_back(tbl[2]);
      issue(); drain();
      chk("wrap", 32'(done_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
